// File: rtl/tournament_sched.sv
// Knockout-bracket scheduler: one match resource is time-shared across all rounds.
// Optional abort input is compiled in with `define TOURNAMENT_SCHED_ABORT_EN.
module tournament_sched #(
    parameter int NUM_TEAMS = 4,
    parameter int ID_W      = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
`ifdef TOURNAMENT_SCHED_ABORT_EN
    input  logic                         abort,
`endif
    output logic                         busy,
    output logic                         match_valid,
    input  logic                         match_ready,
    output logic [ID_W-1:0]              team_one,
    output logic [ID_W-1:0]              team_two,
    output logic [$clog2(NUM_TEAMS)-1:0] round,
    input  logic                         result_valid,
    input  logic                         result_sel,
    output logic [ID_W-1:0]              champion,
    output logic                         done
);

    // state | meaning
    // IDLE  | waiting for start
    // ISSUE | pairing presented, waiting for match_ready
    // WAIT  | pairing accepted, waiting for result_valid
    // DONE  | final recorded, one-cycle done pulse
    localparam int CNT_W = $clog2(NUM_TEAMS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [ID_W-1:0]  slot [NUM_TEAMS];
    logic [CNT_W:0]   remaining;
    logic [CNT_W-1:0] k;
    logic [CNT_W-1:0] idx_one;
    logic [CNT_W-1:0] idx_two;
    logic [CNT_W:0]   half;
    logic [CNT_W:0]   k_inc;
    logic             last_in_round;
    logic             final_round;
    logic             abort_hit;
    logic             result_take;
    logic [ID_W-1:0]  winner;

`ifdef TOURNAMENT_SCHED_ABORT_EN
    assign abort_hit = abort && (state != S_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // k < remaining/2 always holds, so the doubled index never overflows CNT_W bits.
    assign idx_one       = CNT_W'({k, 1'b0});
    assign idx_two       = idx_one + CNT_W'(1);
    assign half          = remaining >> 1;
    assign k_inc         = {1'b0, k} + (CNT_W+1)'(1);
    assign last_in_round = (k_inc >= half);
    assign final_round   = (half <= (CNT_W+1)'(1));
    assign winner        = result_sel ? slot[idx_two] : slot[idx_one];
    assign result_take   = (state == S_WAIT) && result_valid && !abort_hit;

    assign team_one = slot[idx_one];
    assign team_two = slot[idx_two];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        busy        = 1'b0;
        match_valid = 1'b0;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy        = 1'b1;
                match_valid = 1'b1;
                if (match_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                busy = 1'b1;
                if (result_valid) begin
                    if (!last_in_round || !final_round) begin
                        state_next = S_ISSUE;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (abort_hit) begin
            state_next = S_IDLE;
        end
    end

    // Winner of match k lands in slot[k]; its sources 2k and 2k+1 are already consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TEAMS; i++) begin
                slot[i] <= '0;
            end
            remaining <= '0;
            k         <= '0;
            round     <= '0;
            champion  <= '0;
        end else if ((state == S_IDLE) && start) begin
            for (int i = 0; i < NUM_TEAMS; i++) begin
                slot[i] <= ID_W'(i);
            end
            remaining <= (CNT_W+1)'(NUM_TEAMS);
            k         <= '0;
            round     <= '0;
        end else if (result_take) begin
            slot[k] <= winner;
            if (!last_in_round) begin
                k <= k + CNT_W'(1);
            end else if (!final_round) begin
                remaining <= half;
                round     <= round + CNT_W'(1);
                k         <= '0;
            end else begin
                champion <= winner;
            end
        end
    end

endmodule

// File: tb/tb_tournament_sched.sv
// Directed bench for tournament_sched: a 4-team and an 8-team instance share stimulus;
// match tables hold the pairings and results, hand sequences cover the multi-cycle cases.
module tb_tournament_sched;

    typedef struct {
        logic sel;
        int   t1;
        int   t2;
        int   rd;
    } match_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic match_ready;
    logic result_valid;
    logic result_sel;
`ifdef TOURNAMENT_SCHED_ABORT_EN
    logic abort;
`endif

    logic       bz4, mv4, dn4;
    logic [1:0] t14, t24, ch4, rd4;
    logic       bz8, mv8, dn8;
    logic [2:0] t18, t28, ch8, rd8;

    bit         sel8 = 1'b0;
    logic       mv, dn, bz;
    logic [2:0] t1, t2, rd, ch;

    int compared   = 0;
    int mismatched = 0;
    int hs_cnt     = 0;
    int done_cnt   = 0;

    match_t vec [13];

    always #5 clk = ~clk;

    tournament_sched #(.NUM_TEAMS(4), .ID_W(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef TOURNAMENT_SCHED_ABORT_EN
        .abort(abort),
`endif
        .busy(bz4), .match_valid(mv4), .match_ready(match_ready),
        .team_one(t14), .team_two(t24), .round(rd4),
        .result_valid(result_valid), .result_sel(result_sel),
        .champion(ch4), .done(dn4)
    );

    tournament_sched #(.NUM_TEAMS(8), .ID_W(3)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef TOURNAMENT_SCHED_ABORT_EN
        .abort(abort),
`endif
        .busy(bz8), .match_valid(mv8), .match_ready(match_ready),
        .team_one(t18), .team_two(t28), .round(rd8),
        .result_valid(result_valid), .result_sel(result_sel),
        .champion(ch8), .done(dn8)
    );

    always_comb begin
        mv = sel8 ? mv8 : mv4;
        dn = sel8 ? dn8 : dn4;
        bz = sel8 ? bz8 : bz4;
        t1 = sel8 ? t18 : {1'b0, t14};
        t2 = sel8 ? t28 : {1'b0, t24};
        rd = sel8 ? rd8 : {1'b0, rd4};
        ch = sel8 ? ch8 : {1'b0, ch4};
    end

    always @(posedge clk) begin
        if (mv && match_ready) hs_cnt <= hs_cnt + 1;
        if (dn) done_cnt <= done_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_tourn(input int first, input int cnt, input int champ,
                             input bit hold_ready, input int bp, input bit spur);
        int hs0;
        int dn0;
        hs0 = hs_cnt;
        dn0 = done_cnt;
        if (spur) begin
            result_valid = 1'b1;
            result_sel   = 1'b1;
            step();
            result_valid = 1'b0;
            check("idle_spur_busy", int'(bz), 0);
            check("idle_spur_valid", int'(mv), 0);
        end
        start = 1'b1;
        if (hold_ready) match_ready = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_start", int'(bz), 1);
        for (int m = 0; m < cnt; m++) begin
            int w;
            w = 0;
            while (!mv && w < 10) begin
                step();
                w++;
            end
            check("match_valid", int'(mv), 1);
            check("team_one", int'(t1), vec[first+m].t1);
            check("team_two", int'(t2), vec[first+m].t2);
            check("round", int'(rd), vec[first+m].rd);
            if (m == 0) begin
                for (int c = 0; c < bp; c++) begin
                    step();
                    check("bp_valid", int'(mv), 1);
                    check("bp_team_one", int'(t1), vec[first].t1);
                    check("bp_team_two", int'(t2), vec[first].t2);
                    check("bp_round", int'(rd), vec[first].rd);
                end
            end
            if (spur) begin
                result_valid = 1'b1;
                result_sel   = 1'b1;
                start        = 1'b1;
                step();
                result_valid = 1'b0;
                start        = 1'b0;
                check("spur_valid", int'(mv), 1);
                check("spur_team_one", int'(t1), vec[first+m].t1);
                check("spur_team_two", int'(t2), vec[first+m].t2);
                check("spur_round", int'(rd), vec[first+m].rd);
            end
            match_ready = 1'b1;
            step();
            if (!hold_ready) match_ready = 1'b0;
            check("valid_low_in_wait", int'(mv), 0);
            result_valid = 1'b1;
            result_sel   = vec[first+m].sel;
            step();
            result_valid = 1'b0;
        end
        check("done_pulse", int'(dn), 1);
        check("champion", int'(ch), champ);
        check("busy_in_done", int'(bz), 1);
        step();
        match_ready = 1'b0;
        check("done_cleared", int'(dn), 0);
        check("busy_cleared", int'(bz), 0);
        check("champion_held", int'(ch), champ);
        check("handshakes", hs_cnt - hs0, cnt);
        check("done_count", done_cnt - dn0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0]  = '{sel: 1'b0, t1: 0, t2: 1, rd: 0};
        vec[1]  = '{sel: 1'b0, t1: 2, t2: 3, rd: 0};
        vec[2]  = '{sel: 1'b0, t1: 0, t2: 2, rd: 1};
        vec[3]  = '{sel: 1'b1, t1: 0, t2: 1, rd: 0};
        vec[4]  = '{sel: 1'b0, t1: 2, t2: 3, rd: 0};
        vec[5]  = '{sel: 1'b1, t1: 1, t2: 2, rd: 1};
        vec[6]  = '{sel: 1'b1, t1: 0, t2: 1, rd: 0};
        vec[7]  = '{sel: 1'b1, t1: 2, t2: 3, rd: 0};
        vec[8]  = '{sel: 1'b1, t1: 4, t2: 5, rd: 0};
        vec[9]  = '{sel: 1'b1, t1: 6, t2: 7, rd: 0};
        vec[10] = '{sel: 1'b1, t1: 1, t2: 3, rd: 1};
        vec[11] = '{sel: 1'b1, t1: 5, t2: 7, rd: 1};
        vec[12] = '{sel: 1'b1, t1: 3, t2: 7, rd: 2};

        rst_n        = 1'b0;
        start        = 1'b0;
        match_ready  = 1'b0;
        result_valid = 1'b0;
        result_sel   = 1'b0;
`ifdef TOURNAMENT_SCHED_ABORT_EN
        abort        = 1'b0;
`endif
        step();
        step();
        check("rst_busy", int'(bz), 0);
        check("rst_valid", int'(mv), 0);
        check("rst_done", int'(dn), 0);
        check("rst_champion", int'(ch), 0);
        check("rst_round", int'(rd), 0);
        check("rst_team_one", int'(t1), 0);
        check("rst_team_two", int'(t2), 0);
        rst_n = 1'b1;
        step();

        run_tourn(0, 3, 0, 1'b1, 0, 1'b0);
        run_tourn(3, 3, 2, 1'b0, 0, 1'b0);
        run_tourn(3, 3, 2, 1'b0, 5, 1'b0);
        run_tourn(3, 3, 2, 1'b0, 0, 1'b1);

        // Interrupt the tournament while waiting on the second match's result.
        start = 1'b1;
        step();
        start = 1'b0;
        match_ready = 1'b1;
        step();
        match_ready  = 1'b0;
        result_valid = 1'b1;
        result_sel   = 1'b0;
        step();
        result_valid = 1'b0;
        match_ready  = 1'b1;
        step();
        match_ready = 1'b0;
        check("mid_wait_valid", int'(mv), 0);
        check("mid_wait_busy", int'(bz), 1);
`ifdef TOURNAMENT_SCHED_ABORT_EN
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", int'(bz), 0);
        check("abort_valid", int'(mv), 0);
        check("abort_done", int'(dn), 0);
        check("abort_champion", int'(ch), 2);
`else
        rst_n = 1'b0;
        #2;
        check("async_rst_busy", int'(bz), 0);
        check("async_rst_valid", int'(mv), 0);
        check("async_rst_done", int'(dn), 0);
        check("async_rst_champion", int'(ch), 0);
        check("async_rst_round", int'(rd), 0);
        check("async_rst_team_one", int'(t1), 0);
        check("async_rst_team_two", int'(t2), 0);
        step();
        rst_n = 1'b1;
        step();
`endif
        start = 1'b1;
        step();
        start = 1'b0;
        check("replay_valid", int'(mv), 1);
        check("replay_team_one", int'(t1), 0);
        check("replay_team_two", int'(t2), 1);
        check("replay_round", int'(rd), 0);

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        sel8  = 1'b1;
        step();
        run_tourn(6, 7, 7, 1'b0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
